polyphase_interp_fir_21: RTL and testbench
==========================================

// Module: polyphase_interp_fir_21
// PURPOSE
//  3x polyphase interpolation FIR. Same 21-tap prototype as the decimator (hdec) path; this is its upsampling counterpart.
//  Accepts one input sample per handshake and emits 3 output samples, one per phase, over following output handshakes.
//  Sits between the baseband sample source and the DAC-side datapath.
//  Uses a 7-deep input delay line with constant-coefficient shift-add products selected per phase.
// PARAMETERS
//  word_size_in   8   bit-size of input X, two's complement
//  word_size_out  20  bit-size of output Y, two's complement
//  L              3   interpolation factor. Fixed by the coefficient table; other values unsupported.
//  TAPS_PER_PH    7   taps per phase = ceil(21/L). Fixed.
// PORTS
//  clk      in   1              rising-edge clock
//  reset    in   1              synchronous, active-high reset
//  X        in   word_size_in   input sample
//  x_valid  in   1              X valid
//  x_ready  out  1              block can accept X this cycle
//  Y        out  word_size_out  output sample
//  y_valid  out  1              Y valid
//  y_ready  in   1              downstream accepts Y this cycle
// BEHAVIOUR
//  - Clock and reset: one clock (clk). reset is synchronous and active-high.
//  - Coefficients h[0..20] = -1,2,7,8,-6,-30,-34,17,119,220,255,199,91,-2,-37,-25,-1,9,6,0,-1.
//  - Phase p (0..2) output: y[3n+p] = sum_k h[p+3k]*x[n-k], for k = 0..6.
//    Products are built by shift-add only; no multipliers.
//  - Phase DC gains: 265, 265, 266. Worst-case |sum| = 402*128 = 51456, which fits in 17 bits.
//  - Y is the sign-extended result. No saturation or rounding is needed.
//  - Reset state: x_ready=1, y_valid=0, Y=0, delay line all 0, phase=0, FSM in IDLE.
//  - FSM states:
//    IDLE: x_ready=1, y_valid=0.
//      On x_valid: shift X into d[0] (d[k] <= d[k-1]), register the phase-0 sum into Y,
//      set y_valid=1, phase=0, go to RUN.
//    RUN: y_valid=1. On y_ready (output accepted):
//      - phase<2: phase++, register the next phase sum into Y.
//      - phase==2 and x_valid: back-to-back accept. Shift X in, Y = new phase-0 sum, phase=0, stay in RUN.
//      - phase==2 and !x_valid: y_valid=0, go to IDLE.
//  - x_ready = IDLE | (RUN & phase==2 & y_ready). This is combinational from state and y_ready.
//  - Latency: X accepted at edge t gives phase-0 Y valid after edge t (visible in cycle t+1).
//    Phases 1 and 2 follow on consecutive accepted cycles.
//  - Throughput: 1 output per cycle when y_ready is held high.
//    Input throughput is 1 sample per 3 cycles with no bubbles.
//  - Backpressure: while y_valid & !y_ready, Y, phase and the delay line are held. x_ready=0.
//  - x_valid while x_ready=0 is ignored. The source must hold X.
//  - reset asserted mid-burst: next cycle is the reset state. Pending phases are discarded.
//  - The delay line is not cleared between bursts; history persists across IDLE.
// TESTING
//  - Impulse: reset, then X=1 followed by X=0 x6, y_ready=1.
//    Required: Y stream -1,2,7,8,-6,-30,...,6,0,-1 (h[0..20]), then 0s.
//  - DC: X=100 held.
//    Required: after 7 inputs, Y repeats 26500,26500,26600. X=-128 gives -33920,-33920,-34048.
//  - Backpressure: y_ready=0 for 5 cycles during phase 1.
//    Required: Y, y_valid stable and x_ready=0 throughout. Sequence resumes intact.
//  - Back-to-back: x_valid=1 continuously, y_ready=1.
//    Required: x_ready pulses exactly every 3rd cycle. y_valid stays high with no gaps.
//  - Reset mid-burst: assert reset during phase 1.
//    Required: next cycle y_valid=0, Y=0, x_ready=1. A following impulse reproduces h[0..20].
//  - Idle gap: impulse, 10 idle cycles, then X=1.
//    Required: the 2nd response overlays the 1st correctly, continuing from the retained delay line.

Source files
------------

// File: rtl/polyphase_interp_fir_21.sv
// 3x polyphase interpolation FIR on the 21-tap prototype: one input sample yields
// three outputs (one per phase), built from shift-add constant products over a 7-deep delay line.
module polyphase_interp_fir_21 #(
  parameter int word_size_in  = 8,
  parameter int word_size_out = 20,
  parameter int L             = 3,
  parameter int TAPS_PER_PH   = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [word_size_in-1:0]  X,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic [word_size_out-1:0] Y,
  output logic                     y_valid,
  input  logic                     y_ready
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] PHASE_LAST = 2'(L - 1);

  state_t                          state;
  state_t                          state_nxt;
  logic [word_size_in-1:0]         d [TAPS_PER_PH];
  logic [1:0]                      phase;
  logic [1:0]                      phase_sel;
  logic                            accept;
  logic                            advance;
  logic signed [word_size_out-1:0] taps [TAPS_PER_PH];
  logic signed [word_size_out-1:0] acc;

  // h[idx] * x using shifts and adds only
  function automatic logic signed [word_size_out-1:0] coef_mul(
    input logic signed [word_size_out-1:0] x,
    input logic [4:0]                      idx
  );
    case (idx)
      5'd0:    coef_mul = -x;
      5'd1:    coef_mul = x <<< 1;
      5'd2:    coef_mul = (x <<< 3) - x;
      5'd3:    coef_mul = x <<< 3;
      5'd4:    coef_mul = -((x <<< 2) + (x <<< 1));
      5'd5:    coef_mul = -((x <<< 5) - (x <<< 1));
      5'd6:    coef_mul = -((x <<< 5) + (x <<< 1));
      5'd7:    coef_mul = (x <<< 4) + x;
      5'd8:    coef_mul = (x <<< 7) - (x <<< 3) - x;
      5'd9:    coef_mul = (x <<< 8) - (x <<< 5) - (x <<< 2);
      5'd10:   coef_mul = (x <<< 8) - x;
      5'd11:   coef_mul = (x <<< 8) - (x <<< 6) + (x <<< 3) - x;
      5'd12:   coef_mul = (x <<< 6) + (x <<< 5) - (x <<< 2) - x;
      5'd13:   coef_mul = -(x <<< 1);
      5'd14:   coef_mul = -((x <<< 5) + (x <<< 2) + x);
      5'd15:   coef_mul = -((x <<< 4) + (x <<< 3) + x);
      5'd16:   coef_mul = -x;
      5'd17:   coef_mul = (x <<< 3) + x;
      5'd18:   coef_mul = (x <<< 2) + (x <<< 1);
      5'd19:   coef_mul = {word_size_out{1'b0}};
      5'd20:   coef_mul = -x;
      default: coef_mul = {word_size_out{1'b0}};
    endcase
  endfunction

  assign x_ready = (state == IDLE) | ((state == RUN) & (phase == PHASE_LAST) & y_ready);

  // next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (x_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!y_ready) begin
          state_nxt = RUN;
        end else if (phase != PHASE_LAST) begin
          advance = 1'b1;
        end else if (x_valid) begin
          accept = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // phase sum over the delay line as it will be after this edge
  always_comb begin
    phase_sel = accept ? 2'd0 : phase + 2'd1;
    acc       = {word_size_out{1'b0}};
    for (int k = 0; k < TAPS_PER_PH; k++) begin
      if (accept) begin
        if (k == 0) begin
          taps[k] = {{(word_size_out - word_size_in){X[word_size_in-1]}}, X};
        end else begin
          taps[k] = {{(word_size_out - word_size_in){d[k-1][word_size_in-1]}}, d[k-1]};
        end
      end else begin
        taps[k] = {{(word_size_out - word_size_in){d[k][word_size_in-1]}}, d[k]};
      end
      acc = acc + coef_mul(taps[k], {3'b000, phase_sel} + 5'(3 * k));
    end
  end

  // state, delay line and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 2'd0;
      Y       <= {word_size_out{1'b0}};
      y_valid <= 1'b0;
      for (int k = 0; k < TAPS_PER_PH; k++) d[k] <= {word_size_in{1'b0}};
    end else begin
      state   <= state_nxt;
      y_valid <= (state_nxt == RUN);
      if (accept) begin
        d[0] <= X;
        for (int k = 1; k < TAPS_PER_PH; k++) d[k] <= d[k-1];
        Y     <= acc;
        phase <= 2'd0;
      end else if (advance) begin
        Y     <= acc;
        phase <= phase_sel;
      end else begin
        Y     <= Y;
        phase <= phase;
      end
    end
  end

endmodule

// File: tb/tb_polyphase_interp_fir_21.sv
// Scoreboard bench for polyphase_interp_fir_21: a multiply-based reference model pushes the
// three expected phase outputs on each accepted input; outputs are popped on each output handshake.
module tb_polyphase_interp_fir_21;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  X;
  logic        x_valid;
  logic        x_ready;
  logic [19:0] Y;
  logic        y_valid;
  logic        y_ready;

  polyphase_interp_fir_21 dut (
    .clk(clk), .reset(reset), .X(X), .x_valid(x_valid), .x_ready(x_ready),
    .Y(Y), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int h [21] = '{-1, 2, 7, 8, -6, -30, -34, 17, 119, 220, 255, 199, 91, -2, -37, -25, -1, 9, 6, 0, -1};
  int md [7];
  int exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int s_y;
  logic s_yv, s_xr, s_acc;

  task automatic check_val(input string tag, input int got, input int expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 7; k++) md[k] = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int xs);
    int s;
    for (int k = 6; k > 0; k--) md[k] = md[k-1];
    md[0] = xs;
    for (int p = 0; p < 3; p++) begin
      s = 0;
      for (int k = 0; k < 7; k++) s += h[p + 3*k] * md[k];
      exp_q.push_back(s);
    end
  endtask

  // one clock: drive at negedge, sample mid-cycle, score handshakes, advance past posedge
  task automatic cycle(input logic rst, input logic xv, input int xs, input logic yr);
    int e;
    @(negedge clk);
    reset = rst; x_valid = xv; X = 8'(xs); y_ready = yr;
    #2;
    s_y = $signed(Y); s_yv = y_valid; s_xr = x_ready;
    s_acc = 1'b0;
    if (!rst) begin
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) check_val("unexpected_output", s_y, 99999999);
        else begin
          e = exp_q.pop_front();
          check_val("y_stream", s_y, e);
        end
      end
      if (x_valid && x_ready) begin
        model_accept(xs);
        s_acc = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic push_sample(input int xs);
    int n = 0;
    do begin
      cycle(1'b0, 1'b1, xs, 1'b1);
      n++;
    end while (!s_acc && n < 20);
    if (!s_acc) check_val("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 0, 1'b0);
    model_reset();
    #1;
    check_val("rst_x_ready", int'(x_ready), 1);
    check_val("rst_y_valid", int'(y_valid), 0);
    check_val("rst_Y", int'(Y), 0);
  endtask

  task automatic impulse();
    push_sample(1);
    for (int i = 0; i < 6; i++) push_sample(0);
    drain(6);
  endtask

  int hold_y;

  initial begin
    reset = 1'b1; X = 8'd0; x_valid = 1'b0; y_ready = 1'b0;
    do_reset();

    // impulse reproduces h[0..20]
    impulse();
    check_val("impulse_q_empty", exp_q.size(), 0);

    // DC +100 then -128, also checked against fixed gains
    for (int i = 0; i < 9; i++) push_sample(100);
    check_val("dc_pos_p0", exp_q[0], 26500);
    check_val("dc_pos_p2", exp_q[2], 26600);
    drain(6);
    for (int i = 0; i < 9; i++) push_sample(-128);
    check_val("dc_neg_p1", exp_q[1], -33920);
    check_val("dc_neg_p2", exp_q[2], -34048);
    drain(6);

    // backpressure during phase 1
    push_sample(57);
    cycle(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 33, 1'b0);
      if (i == 0) hold_y = s_y;
      check_val("bp_y_stable", s_y, hold_y);
      check_val("bp_y_valid", int'(s_yv), 1);
      check_val("bp_x_ready", int'(s_xr), 0);
    end
    drain(6);
    check_val("bp_q_empty", exp_q.size(), 0);

    // back-to-back: x_ready every third cycle, y_valid without gaps
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'b1, int'($urandom_range(0, 255)) - 128, 1'b1);
      check_val("b2b_x_ready", int'(s_xr), (i % 3 == 0) ? 1 : 0);
      if (i > 0) check_val("b2b_y_valid", int'(s_yv), 1);
    end
    drain(6);
    check_val("b2b_q_empty", exp_q.size(), 0);

    // reset mid-burst, then impulse from clean state
    push_sample(-77);
    cycle(1'b0, 1'b0, 0, 1'b1);
    do_reset();
    impulse();
    check_val("rst_imp_q_empty", exp_q.size(), 0);

    // idle gap: second impulse overlays retained history
    push_sample(1);
    drain(10);
    push_sample(1);
    for (int i = 0; i < 6; i++) push_sample(0);
    drain(6);
    check_val("gap_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
